// File: rtl/i2s_receiver.sv
// I2S receiver: oversampled BCK/LRCK/DATA capture into stereo sample pairs.
// Detects short/long slots, keeps pair integrity and counts framing errors.
module i2s_receiver #(
    parameter int DATA_WIDTH = 24,
    parameter int SLOT_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  BCK_ADAU,
    input  logic                  LRCK_ADAU,
    input  logic                  DATA_ADAU,
    output logic [DATA_WIDTH-1:0] left_sample,
    output logic [DATA_WIDTH-1:0] right_sample,
    output logic                  sample_valid,
    output logic                  frame_err,
    output logic [7:0]            err_count
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        PAD
    } state_t;

    localparam int CW = 7;
    localparam logic [CW-1:0] DW_C = CW'(DATA_WIDTH);
    localparam logic [CW-1:0] SW_C = CW'(SLOT_WIDTH);

    logic [1:0]            bck_sync_q;
    logic [1:0]            lrck_sync_q;
    logic [1:0]            data_sync_q;
    logic                  bck_prev_q;

    logic                  bck_s;
    logic                  lrck_s;
    logic                  data_s;
    logic                  bck_evt;
    logic                  boundary;

    state_t                state_q, state_d;
    logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
    logic                  chan_q, chan_d;
    logic                  lrck_last_q, lrck_last_d;
    logic                  armed_q, armed_d;
    logic                  left_ok_q, left_ok_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] left_hold_q, left_hold_d;

    logic [DATA_WIDTH-1:0] shift_nx;
    logic [CW-1:0]         cnt_inc;
    logic                  load_pair;
    logic                  err_pulse;

    logic [DATA_WIDTH-1:0] left_q;
    logic [DATA_WIDTH-1:0] right_q;
    logic                  valid_q;
    logic                  err_q;
    logic [7:0]            err_cnt_q;

    assign bck_s    = bck_sync_q[1];
    assign lrck_s   = lrck_sync_q[1];
    assign data_s   = data_sync_q[1];
    assign bck_evt  = bck_s & ~bck_prev_q;
    assign boundary = lrck_s ^ lrck_last_q;
    assign shift_nx = {shift_q[DATA_WIDTH-2:0], data_s};
    assign cnt_inc  = bit_cnt_q + 1'b1;

    // Two-flop synchronizers plus BCK edge history register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bck_sync_q  <= '0;
            lrck_sync_q <= '0;
            data_sync_q <= '0;
            bck_prev_q  <= 1'b0;
        end else begin
            bck_sync_q  <= {bck_sync_q[0], BCK_ADAU};
            lrck_sync_q <= {lrck_sync_q[0], LRCK_ADAU};
            data_sync_q <= {data_sync_q[0], DATA_ADAU};
            bck_prev_q  <= bck_s;
        end
    end

    // Slot FSM state and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            chan_q      <= 1'b0;
            lrck_last_q <= 1'b0;
            armed_q     <= 1'b0;
            left_ok_q   <= 1'b0;
            shift_q     <= '0;
            left_hold_q <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            chan_q      <= chan_d;
            lrck_last_q <= lrck_last_d;
            armed_q     <= armed_d;
            left_ok_q   <= left_ok_d;
            shift_q     <= shift_d;
            left_hold_q <= left_hold_d;
        end
    end

    // Next-state logic; acts only on BCK events. The first event after
    // reset just samples LRCK so a mid-slot release cannot fake a boundary.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        chan_d      = chan_q;
        lrck_last_d = lrck_last_q;
        armed_d     = armed_q;
        left_ok_d   = left_ok_q;
        shift_d     = shift_q;
        left_hold_d = left_hold_q;
        load_pair   = 1'b0;
        err_pulse   = 1'b0;
        if (bck_evt) begin
            lrck_last_d = lrck_s;
            armed_d     = 1'b1;
            if (armed_q) begin
                unique case (state_q)
                    IDLE: begin
                        left_ok_d = 1'b0;
                        if (boundary) begin
                            state_d   = SHIFT;
                            bit_cnt_d = '0;
                            chan_d    = lrck_s;
                        end
                    end
                    SHIFT: begin
                        if (boundary) begin
                            err_pulse = 1'b1;
                            left_ok_d = 1'b0;
                            bit_cnt_d = '0;
                            chan_d    = lrck_s;
                            shift_d   = '0;
                        end else begin
                            shift_d   = shift_nx;
                            bit_cnt_d = cnt_inc;
                            if (cnt_inc == DW_C) begin
                                state_d = PAD;
                                if (!chan_q) begin
                                    left_hold_d = shift_nx;
                                    left_ok_d   = 1'b1;
                                end else begin
                                    load_pair = left_ok_q;
                                    left_ok_d = 1'b0;
                                end
                            end
                        end
                    end
                    PAD: begin
                        if (boundary) begin
                            state_d   = SHIFT;
                            bit_cnt_d = '0;
                            chan_d    = lrck_s;
                        end else begin
                            bit_cnt_d = cnt_inc;
                            if (cnt_inc >= SW_C) begin
                                err_pulse = 1'b1;
                                left_ok_d = 1'b0;
                                state_d   = IDLE;
                            end
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    // Output words, one-cycle pulses and saturating error counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            left_q    <= '0;
            right_q   <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            valid_q <= load_pair;
            err_q   <= err_pulse;
            if (load_pair) begin
                left_q  <= left_hold_q;
                right_q <= shift_nx;
            end
            if (err_pulse && (err_cnt_q != 8'hFF)) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
        end
    end

    assign left_sample  = left_q;
    assign right_sample = right_q;
    assign sample_valid = valid_q;
    assign frame_err    = err_q;
    assign err_count    = err_cnt_q;

endmodule

// File: tb/tb_i2s_receiver.sv
// Directed testbench for i2s_receiver: framing, errors, reset, saturation.
// Each task drives its own scenario and checks results inline.
module tb_i2s_receiver;

    logic        clk;
    logic        rst_n;
    logic        BCK_ADAU;
    logic        LRCK_ADAU;
    logic        DATA_ADAU;
    logic [23:0] left_sample;
    logic [23:0] right_sample;
    logic        sample_valid;
    logic        frame_err;
    logic [7:0]  err_count;

    int vecs = 0;
    int errs = 0;
    int sv_cnt = 0;
    int fe_cnt = 0;
    int half = 160;
    logic [23:0] last_l = '0;
    logic [23:0] last_r = '0;

    i2s_receiver #(.DATA_WIDTH(24), .SLOT_WIDTH(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .BCK_ADAU     (BCK_ADAU),
        .LRCK_ADAU    (LRCK_ADAU),
        .DATA_ADAU    (DATA_ADAU),
        .left_sample  (left_sample),
        .right_sample (right_sample),
        .sample_valid (sample_valid),
        .frame_err    (frame_err),
        .err_count    (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse monitor: counts high cycles of sample_valid / frame_err.
    always @(negedge clk) begin
        if (sample_valid) begin
            sv_cnt = sv_cnt + 1;
            last_l = left_sample;
            last_r = right_sample;
        end
        if (frame_err) fe_cnt = fe_cnt + 1;
    end

    task automatic send_bit(input logic lr, input logic d);
        BCK_ADAU  = 1'b0;
        LRCK_ADAU = lr;
        DATA_ADAU = d;
        #(half);
        BCK_ADAU  = 1'b1;
        #(half);
    endtask

    // Slot bits first..last; bit 0 is the delay bit, 1..24 carry MSB..LSB.
    task automatic send_range(input logic lr, input logic [23:0] w,
                              input int first, input int last);
        for (int i = first; i <= last; i++) begin
            if (i >= 1 && i <= 24) send_bit(lr, w[24-i]);
            else send_bit(lr, 1'b0);
        end
    endtask

    task automatic do_reset();
        BCK_ADAU  = 1'b0;
        LRCK_ADAU = 1'b0;
        DATA_ADAU = 1'b0;
        rst_n     = 1'b0;
        #40;
        rst_n = 1'b1;
        #40;
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
    endtask

    task automatic test_reset();
        BCK_ADAU  = 1'b0;
        LRCK_ADAU = 1'b0;
        DATA_ADAU = 1'b0;
        rst_n     = 1'b0;
        #40;
        vecs++;
        if (left_sample !== 24'h0) begin
            errs++;
            $display("FAIL reset_left got %h want 000000", left_sample);
        end
        vecs++;
        if (right_sample !== 24'h0) begin
            errs++;
            $display("FAIL reset_right got %h want 000000", right_sample);
        end
        vecs++;
        if (sample_valid !== 1'b0) begin
            errs++;
            $display("FAIL reset_valid got %b want 0", sample_valid);
        end
        vecs++;
        if (frame_err !== 1'b0) begin
            errs++;
            $display("FAIL reset_ferr got %b want 0", frame_err);
        end
        vecs++;
        if (err_count !== 8'h0) begin
            errs++;
            $display("FAIL reset_errcnt got %0d want 0", err_count);
        end
    endtask

    task automatic test_right_first();
        int v0;
        int e0;
        do_reset();
        v0 = sv_cnt;
        e0 = fe_cnt;
        send_range(1'b1, 24'h777777, 0, 31);
        vecs++;
        if (sv_cnt - v0 !== 0) begin
            errs++;
            $display("FAIL rfirst_novalid got %0d want 0", sv_cnt - v0);
        end
        send_range(1'b0, 24'h111111, 0, 31);
        send_range(1'b1, 24'h222222, 0, 31);
        vecs++;
        if (sv_cnt - v0 !== 1) begin
            errs++;
            $display("FAIL rfirst_count got %0d want 1", sv_cnt - v0);
        end
        vecs++;
        if (last_l !== 24'h111111 || last_r !== 24'h222222) begin
            errs++;
            $display("FAIL rfirst_pair got %h/%h want 111111/222222",
                     last_l, last_r);
        end
        vecs++;
        if (fe_cnt - e0 !== 0) begin
            errs++;
            $display("FAIL rfirst_ferr got %0d want 0", fe_cnt - e0);
        end
    endtask

    task automatic test_standard();
        logic [23:0] lv [3];
        logic [23:0] rv [3];
        int v0;
        int e0;
        lv[0] = 24'hA5C3F1; rv[0] = 24'h123456;
        lv[1] = 24'hA5C3F1; rv[1] = 24'h123456;
        lv[2] = 24'h800000; rv[2] = 24'h000001;
        do_reset();
        send_range(1'b1, 24'h0, 0, 31);
        v0 = sv_cnt;
        e0 = fe_cnt;
        for (int f = 0; f < 3; f++) begin
            send_range(1'b0, lv[f], 0, 31);
            send_range(1'b1, rv[f], 0, 23);
            vecs++;
            if (sv_cnt - v0 !== f) begin
                errs++;
                $display("FAIL std_early f%0d got %0d want %0d",
                         f, sv_cnt - v0, f);
            end
            send_range(1'b1, rv[f], 24, 24);
            vecs++;
            if (sv_cnt - v0 !== f + 1) begin
                errs++;
                $display("FAIL std_count f%0d got %0d want %0d",
                         f, sv_cnt - v0, f + 1);
            end
            send_range(1'b1, rv[f], 25, 31);
            vecs++;
            if (left_sample !== lv[f] || right_sample !== rv[f]) begin
                errs++;
                $display("FAIL std_pair f%0d got %h/%h want %h/%h",
                         f, left_sample, right_sample, lv[f], rv[f]);
            end
        end
        send_range(1'b0, 24'h0F0F0F, 0, 31);
        vecs++;
        if (left_sample !== 24'h800000 || right_sample !== 24'h000001) begin
            errs++;
            $display("FAIL std_hold got %h/%h want 800000/000001",
                     left_sample, right_sample);
        end
        vecs++;
        if (sv_cnt - v0 !== 3 || fe_cnt - e0 !== 0) begin
            errs++;
            $display("FAIL std_totals got %0d/%0d want 3/0",
                     sv_cnt - v0, fe_cnt - e0);
        end
    endtask

    task automatic test_short_slot();
        int v0;
        int e0;
        do_reset();
        send_range(1'b1, 24'h0, 0, 31);
        v0 = sv_cnt;
        e0 = fe_cnt;
        send_range(1'b0, 24'hABCDEF, 0, 19);
        send_range(1'b1, 24'h654321, 0, 31);
        vecs++;
        if (fe_cnt - e0 !== 1 || err_count !== 8'd1) begin
            errs++;
            $display("FAIL short_err got %0d/%0d want 1/1",
                     fe_cnt - e0, err_count);
        end
        vecs++;
        if (sv_cnt - v0 !== 0) begin
            errs++;
            $display("FAIL short_novalid got %0d want 0", sv_cnt - v0);
        end
        send_range(1'b0, 24'hA5C3F1, 0, 31);
        send_range(1'b1, 24'h123456, 0, 31);
        vecs++;
        if (sv_cnt - v0 !== 1 || last_l !== 24'hA5C3F1 ||
            last_r !== 24'h123456) begin
            errs++;
            $display("FAIL short_recover got %0d %h/%h want 1 a5c3f1/123456",
                     sv_cnt - v0, last_l, last_r);
        end
    endtask

    task automatic test_long_slot();
        int v0;
        int e0;
        do_reset();
        send_range(1'b1, 24'h0, 0, 31);
        v0 = sv_cnt;
        e0 = fe_cnt;
        send_range(1'b0, 24'h13579B, 0, 31);
        vecs++;
        if (fe_cnt - e0 !== 0) begin
            errs++;
            $display("FAIL long_early got %0d want 0", fe_cnt - e0);
        end
        send_range(1'b0, 24'h13579B, 32, 32);
        vecs++;
        if (fe_cnt - e0 !== 1 || err_count !== 8'd1) begin
            errs++;
            $display("FAIL long_err got %0d/%0d want 1/1",
                     fe_cnt - e0, err_count);
        end
        send_range(1'b0, 24'h13579B, 33, 39);
        send_range(1'b1, 24'h246802, 0, 31);
        vecs++;
        if (sv_cnt - v0 !== 0 || fe_cnt - e0 !== 1) begin
            errs++;
            $display("FAIL long_lock got %0d/%0d want 0/1",
                     sv_cnt - v0, fe_cnt - e0);
        end
        send_range(1'b0, 24'hC0FFEE, 0, 31);
        send_range(1'b1, 24'h0BEEF0, 0, 31);
        vecs++;
        if (sv_cnt - v0 !== 1 || last_l !== 24'hC0FFEE ||
            last_r !== 24'h0BEEF0) begin
            errs++;
            $display("FAIL long_recover got %0d %h/%h want 1 c0ffee/0beef0",
                     sv_cnt - v0, last_l, last_r);
        end
    endtask

    task automatic test_reset_mid();
        int v0;
        int e0;
        do_reset();
        send_range(1'b1, 24'h0, 0, 31);
        send_range(1'b0, 24'hA5C3F1, 0, 31);
        send_range(1'b1, 24'h123456, 0, 31);
        send_range(1'b0, 24'h0A0B0C, 0, 31);
        send_range(1'b1, 24'hCCCCCC, 0, 10);
        rst_n = 1'b0;
        #1;
        vecs++;
        if (left_sample !== 24'h0 || right_sample !== 24'h0 ||
            sample_valid !== 1'b0 || frame_err !== 1'b0 ||
            err_count !== 8'h0) begin
            errs++;
            $display("FAIL mid_clear got %h/%h %b %b %0d want all 0",
                     left_sample, right_sample, sample_valid,
                     frame_err, err_count);
        end
        #19;
        rst_n = 1'b1;
        v0 = sv_cnt;
        e0 = fe_cnt;
        send_range(1'b1, 24'hCCCCCC, 11, 31);
        vecs++;
        if (sv_cnt - v0 !== 0) begin
            errs++;
            $display("FAIL mid_novalid got %0d want 0", sv_cnt - v0);
        end
        send_range(1'b0, 24'h5A5A5A, 0, 31);
        send_range(1'b1, 24'h3C3C3C, 0, 31);
        vecs++;
        if (sv_cnt - v0 !== 1 || last_l !== 24'h5A5A5A ||
            last_r !== 24'h3C3C3C) begin
            errs++;
            $display("FAIL mid_pair got %0d %h/%h want 1 5a5a5a/3c3c3c",
                     sv_cnt - v0, last_l, last_r);
        end
        vecs++;
        if (fe_cnt - e0 !== 0) begin
            errs++;
            $display("FAIL mid_lock_ferr got %0d want 0", fe_cnt - e0);
        end
    endtask

    task automatic test_saturate();
        int v0;
        int e0;
        do_reset();
        send_range(1'b1, 24'h0, 0, 31);
        half = 80;
        v0 = sv_cnt;
        e0 = fe_cnt;
        for (int k = 0; k < 300; k++) begin
            send_range((k % 2 == 0) ? 1'b0 : 1'b1, 24'h0, 0, 3);
        end
        send_bit(1'b0, 1'b0);
        vecs++;
        if (fe_cnt - e0 !== 300) begin
            errs++;
            $display("FAIL sat_pulses got %0d want 300", fe_cnt - e0);
        end
        vecs++;
        if (err_count !== 8'd255) begin
            errs++;
            $display("FAIL sat_count got %0d want 255", err_count);
        end
        for (int k = 0; k < 10; k++) begin
            send_range((k % 2 == 0) ? 1'b1 : 1'b0, 24'h0, 0, 3);
        end
        vecs++;
        if (err_count !== 8'd255) begin
            errs++;
            $display("FAIL sat_hold got %0d want 255", err_count);
        end
        vecs++;
        if (sv_cnt - v0 !== 0) begin
            errs++;
            $display("FAIL sat_novalid got %0d want 0", sv_cnt - v0);
        end
        half = 160;
    endtask

    initial begin
        test_reset();
        test_right_first();
        test_standard();
        test_short_slot();
        test_long_slot();
        test_reset_mid();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
